cmp_arb: RTL

CMP_ARB -- requirements
Module: cmp_arb

---
 rtl/cmp_arb.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cmp_arb.sv
// Two-requester arbiter around a single shared 64-bit less-than comparator.
// Define CMP_ARB_RR_EN for round-robin conflict resolution; the default build uses fixed priority (requester 0 wins).
`ifndef REG_BUS
`define REG_BUS 64
`endif

module cmp_arb (
  input  logic                clock,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [`REG_BUS-1:0] req0_op1,
  input  logic [`REG_BUS-1:0] req0_op2,
  input  logic                req0_u,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [`REG_BUS-1:0] req1_op1,
  input  logic [`REG_BUS-1:0] req1_op2,
  input  logic                req1_u,
  output logic                resp0_valid,
  input  logic                resp0_ready,
  output logic [`REG_BUS-1:0] resp0_result,
  output logic                resp1_valid,
  input  logic                resp1_ready,
  output logic [`REG_BUS-1:0] resp1_result
);

  typedef enum logic [1:0] {IDLE = 2'd0, CMP = 2'd1, RESP = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [`REG_BUS-1:0] op1_q, op1_d;
  logic [`REG_BUS-1:0] op2_q, op2_d;
  logic                u_q, u_d;
  logic [`REG_BUS-1:0] result_q, result_d;
  logic                sel_s;
  logic                gnt0_s, gnt1_s;
  logic                lt_s;
  logic                own_ready_s;
`ifdef CMP_ARB_RR_EN
  logic                rr_q, rr_d;
`endif

  // Shared comparator on the latched operands only, so late operand changes cannot leak in.
  always_comb begin
    if (u_q) begin
      lt_s = (op1_q < op2_q);
    end else begin
      lt_s = ($signed(op1_q) < $signed(op2_q));
    end
  end

  // Grant choice; only meaningful while IDLE.
  always_comb begin
`ifdef CMP_ARB_RR_EN
    if (req0_valid && req1_valid) begin
      sel_s = rr_q;
    end else begin
      sel_s = req1_valid;
    end
`else
    sel_s = ~req0_valid;
`endif
  end

  assign own_ready_s = owner_q ? resp1_ready : resp0_ready;

  // Next-state and datapath load logic.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    u_d      = u_q;
    result_d = result_q;
    gnt0_s   = 1'b0;
    gnt1_s   = 1'b0;
`ifdef CMP_ARB_RR_EN
    rr_d     = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          gnt0_s  = ~sel_s;
          gnt1_s  = sel_s;
          owner_d = sel_s;
          op1_d   = sel_s ? req1_op1 : req0_op1;
          op2_d   = sel_s ? req1_op2 : req0_op2;
          u_d     = sel_s ? req1_u : req0_u;
          state_d = CMP;
`ifdef CMP_ARB_RR_EN
          rr_d    = ~sel_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CMP: begin
        result_d = {`REG_BUS{lt_s}};
        state_d  = RESP;
      end
      RESP: begin
        if (own_ready_s) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset mid-transaction drops it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      op1_q    <= {`REG_BUS{1'b0}};
      op2_q    <= {`REG_BUS{1'b0}};
      u_q      <= 1'b0;
      result_q <= {`REG_BUS{1'b0}};
`ifdef CMP_ARB_RR_EN
      rr_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      u_q      <= u_d;
      result_q <= result_d;
`ifdef CMP_ARB_RR_EN
      rr_q     <= rr_d;
`endif
    end
  end

  // All outputs forced low while reset is asserted.
  assign req0_ready   = gnt0_s & ~reset;
  assign req1_ready   = gnt1_s & ~reset;
  assign resp0_valid  = (state_q == RESP) & ~owner_q & ~reset;
  assign resp1_valid  = (state_q == RESP) & owner_q & ~reset;
  assign resp0_result = resp0_valid ? result_q : {`REG_BUS{1'b0}};
  assign resp1_result = resp1_valid ? result_q : {`REG_BUS{1'b0}};

endmodule
